// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the COMET II UART receive path:
//   - rx_state_t   : receive FSM state encoding
//   - WORD_W       : width of an assembled COMET II word
//   - calc_bit_cyc : clock cycles per bit, integer-truncated
//   - even_parity  : parity bit that makes a data byte plus parity even
// Optional feature macro used by the importing modules: UART_RX_PARITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Cycles per bit; truncation keeps the sample point slightly early.
    function automatic int unsigned calc_bit_cyc(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Even parity: returns the bit that makes the 9-bit total even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// Synchronizes the asynchronous RX line, times bit centres with a cycle
// counter and deframes one byte per frame (8N1, or 8E1 when
// UART_RX_PARITY_EN is defined).
// Ports:
//   CLK, RST_N   : clock and synchronous active-low reset
//   RX           : raw serial line, idle high
//   byte_data    : received byte, valid while byte_stb is high
//   byte_stb     : single-cycle strobe in the stop-bit sample cycle of a good byte
//   frame_err    : single-cycle strobe in the sample cycle of a low stop bit
//   parity_err   : single-cycle strobe in the sample cycle of a bad parity bit
//                  (constant 0 when UART_RX_PARITY_EN is undefined)
// Strobes are combinational from the FSM so that the word stage can register
// them and present results one cycle after the offending/final sample.
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 16000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic [7:0] byte_data,
    output logic       byte_stb,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned BIT_CYC = calc_bit_cyc(CLK_HZ, BAUD);
    localparam int unsigned HALF    = BIT_CYC / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);

    logic             rx_meta_r;
    logic             rx_sync_r;
    rx_state_t        state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bit_idx_r, bit_idx_n;
    logic [7:0]       shift_r, shift_n;
    logic             stb_s;
    logic             fe_s;
    logic             pe_s;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_r, par_bad_n;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Deframer state, bit counter and shift register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bad_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            bit_idx_r <= bit_idx_n;
            shift_r   <= shift_n;
`ifdef UART_RX_PARITY_EN
            par_bad_r <= par_bad_n;
`endif
        end
    end

    // Next-state, sampling and strobe generation.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        bit_idx_n = bit_idx_r;
        shift_n   = shift_r;
        stb_s     = 1'b0;
        fe_s      = 1'b0;
        pe_s      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad_r;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_n = {CNT_W{1'b0}};
                if (!rx_sync_r) begin
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_n     = {CNT_W{1'b0}};
                    bit_idx_n = 3'd0;
                    // A line that is high again at mid-start was a glitch.
                    if (rx_sync_r) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = {CNT_W{1'b0}};
                    shift_n = {rx_sync_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = {CNT_W{1'b0}};
                    state_n = ST_STOP;
                    if (rx_sync_r != even_parity(shift_r)) begin
                        pe_s      = 1'b1;
                        par_bad_n = 1'b1;
                    end else begin
                        par_bad_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
`else
                state_n = ST_IDLE;
                cnt_n   = {CNT_W{1'b0}};
`endif
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n = {CNT_W{1'b0}};
                    if (rx_sync_r) begin
                        state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        // A parity failure was already reported; drop silently.
                        stb_s = !par_bad_r;
`else
                        stb_s = 1'b1;
`endif
                    end else begin
                        fe_s    = 1'b1;
                        state_n = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT_HIGH: begin
                // Holding here makes a long break report only one error.
                cnt_n = {CNT_W{1'b0}};
                if (rx_sync_r) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign byte_data  = shift_r;
    assign byte_stb   = stb_s;
    assign frame_err  = fe_s;
    assign parity_err = pe_s;

endmodule

// File: rtl/uart_rx_word.sv
// -----------------------------------------------------------------------------
// uart_rx_word
// UART receive front end: pairs bytes from uart_rx_byte into 16-bit COMET II
// words (first byte in [15:8]) and holds them in a single-entry valid/ready
// output slot.
// Ports:
//   CLK, RST_N  : clock and synchronous active-low reset
//   RX          : asynchronous serial line, idle high
//   WORD_DATA   : assembled word, stable while WORD_VALID is high
//   WORD_VALID  : slot holds an unconsumed word
//   WORD_READY  : consumer accepts when WORD_VALID && WORD_READY
//   FRAME_ERR   : one-cycle pulse, stop bit sampled low
//   OVERRUN     : one-cycle pulse, completed word dropped (slot full)
//   PARITY_ERR  : one-cycle pulse on parity mismatch; constant 0 unless
//                 UART_RX_PARITY_EN is defined
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing when defined).
// -----------------------------------------------------------------------------
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 16000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RX,
    output logic [WORD_W-1:0] WORD_DATA,
    output logic              WORD_VALID,
    input  logic              WORD_READY,
    output logic              FRAME_ERR,
    output logic              OVERRUN,
    output logic              PARITY_ERR
);

    logic [7:0]        byte_data_s;
    logic              byte_stb_s;
    logic              frame_err_s;
    logic              parity_err_s;

    logic              phase_r, phase_n;      // 0: expecting high byte
    logic [7:0]        hi_byte_r, hi_byte_n;
    logic [WORD_W-1:0] word_data_r;
    logic              word_valid_r;
    logic              frame_err_r;
    logic              overrun_r;
    logic              load_s;
    logic              ovr_s;
    logic              hs_s;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_byte (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .RX         (RX),
        .byte_data  (byte_data_s),
        .byte_stb   (byte_stb_s),
        .frame_err  (frame_err_s),
        .parity_err (parity_err_s)
    );

    // Byte pairing and slot-load decision.
    always_comb begin
        hs_s      = word_valid_r && WORD_READY;
        phase_n   = phase_r;
        hi_byte_n = hi_byte_r;
        load_s    = 1'b0;
        ovr_s     = 1'b0;
        if (frame_err_s || parity_err_s) begin
            // Any bad byte abandons a partially assembled word.
            phase_n = 1'b0;
        end else if (byte_stb_s) begin
            if (!phase_r) begin
                hi_byte_n = byte_data_s;
                phase_n   = 1'b1;
            end else begin
                phase_n = 1'b0;
                // Slot counts as free if it is being emptied this cycle.
                if (!word_valid_r || WORD_READY) begin
                    load_s = 1'b1;
                end else begin
                    ovr_s = 1'b1;
                end
            end
        end else begin
            phase_n = phase_r;
        end
    end

    // Pairing state, output slot and registered error pulses.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            phase_r      <= 1'b0;
            hi_byte_r    <= 8'h00;
            word_data_r  <= {WORD_W{1'b0}};
            word_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            phase_r     <= phase_n;
            hi_byte_r   <= hi_byte_n;
            frame_err_r <= frame_err_s;
            overrun_r   <= ovr_s;
            if (load_s) begin
                word_data_r  <= {hi_byte_r, byte_data_s};
                word_valid_r <= 1'b1;
            end else if (hs_s) begin
                word_valid_r <= 1'b0;
            end else begin
                word_valid_r <= word_valid_r;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_r;

    // Registered parity error pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= parity_err_s;
        end
    end

    assign PARITY_ERR = parity_err_r;
`else
    assign PARITY_ERR = 1'b0;
`endif

    assign WORD_DATA  = word_data_r;
    assign WORD_VALID = word_valid_r;
    assign FRAME_ERR  = frame_err_r;
    assign OVERRUN    = overrun_r;

endmodule

// File: tb/tb_uart_rx_word.sv
`timescale 1ns/1ps
module tb_uart_rx_word;

    localparam int BIT_CYC = 138;   // 16000000 / 115200, truncated

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        RX = 1'b1;
    logic        WORD_READY = 1'b1;
    logic [15:0] WORD_DATA;
    logic        WORD_VALID;
    logic        FRAME_ERR;
    logic        OVERRUN;
    logic        PARITY_ERR;
`ifdef UART_RX_PARITY_EN
    logic        bad_par = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Monitor counters, sampled on the falling edge.
    int          hs_cnt = 0;
    int          vcyc_cnt = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          pe_cnt = 0;
    logic [15:0] last_word = 16'h0000;

    uart_rx_word #(.CLK_HZ(16000000), .BAUD(115200)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .RX         (RX),
        .WORD_DATA  (WORD_DATA),
        .WORD_VALID (WORD_VALID),
        .WORD_READY (WORD_READY),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN),
        .PARITY_ERR (PARITY_ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST_N) begin
            if (WORD_VALID && WORD_READY) begin
                hs_cnt    = hs_cnt + 1;
                last_word = WORD_DATA;
            end
            if (WORD_VALID) vcyc_cnt = vcyc_cnt + 1;
            if (FRAME_ERR)  fe_cnt = fe_cnt + 1;
            if (OVERRUN)    ov_cnt = ov_cnt + 1;
            if (PARITY_ERR) pe_cnt = pe_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One frame; the line is left at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        RX = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_cyc(BIT_CYC);
        end
`ifdef UART_RX_PARITY_EN
        RX = (^b) ^ bad_par;
        wait_cyc(BIT_CYC);
`endif
        RX = stop_val;
        wait_cyc(BIT_CYC);
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[5];

    int hs0, vc0, fe0, ov0, pe0;

    task automatic snap();
        hs0 = hs_cnt; vc0 = vcyc_cnt; fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    endtask

    initial begin
        vecs[0] = '{8'h12, 8'h34, 16'h1234};
        vecs[1] = '{8'h00, 8'hFF, 16'h00FF};
        vecs[2] = '{8'hA5, 8'h5A, 16'hA55A};
        vecs[3] = '{8'hFF, 8'h00, 16'hFF00};
        vecs[4] = '{8'h80, 8'h01, 16'h8001};

        // Reset state
        @(posedge CLK); #1;
        wait_cyc(5);
        @(negedge CLK);
        check("rst_data", {16'h0, WORD_DATA}, 32'h0);
        check("rst_flags", {27'h0, WORD_VALID, FRAME_ERR, OVERRUN, PARITY_ERR, 1'b0}, 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        wait_cyc(20);

        // Table: back-to-back byte pairs with READY held high
        WORD_READY = 1'b1;
        for (int v = 0; v < 5; v++) begin
            snap();
            send_byte(vecs[v].b0, 1'b1);
            send_byte(vecs[v].b1, 1'b1);
            wait_cyc(10);
            check("tbl_hs", hs_cnt - hs0, 1);
            check("tbl_word", {16'h0, last_word}, {16'h0, vecs[v].exp});
            check("tbl_vcyc", vcyc_cnt - vc0, 1);
            check("tbl_errs", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
        end

        // Overrun: READY low for four bytes
        WORD_READY = 1'b0;
        snap();
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        wait_cyc(10);
        check("ovr_valid1", {31'h0, WORD_VALID}, 1);
        check("ovr_data1", {16'h0, WORD_DATA}, 32'hABCD);
        send_byte(8'hEF, 1'b1);
        check("ovr_none_yet", ov_cnt - ov0, 0);
        send_byte(8'h01, 1'b1);
        wait_cyc(10);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_data2", {16'h0, WORD_DATA}, 32'hABCD);
        check("ovr_valid2", {31'h0, WORD_VALID}, 1);
        check("ovr_no_hs", hs_cnt - hs0, 0);
        WORD_READY = 1'b1;
        wait_cyc(3);
        check("ovr_hs", hs_cnt - hs0, 1);
        check("ovr_hs_word", {16'h0, last_word}, 32'hABCD);
        check("ovr_valid_clr", {31'h0, WORD_VALID}, 0);

        // Glitch: 3-cycle low pulse must be rejected at mid-start
        snap();
        RX = 1'b0;
        wait_cyc(3);
        RX = 1'b1;
        wait_cyc(200);
        check("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0) + (hs_cnt - hs0), 0);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        wait_cyc(10);
        check("glitch_hs", hs_cnt - hs0, 1);
        check("glitch_word", {16'h0, last_word}, 32'h5AC3);

        // Frame error: bad stop, then a clean word
        snap();
        send_byte(8'h55, 1'b0);
        RX = 1'b1;
        wait_cyc(20);
        check("fe_pulse", fe_cnt - fe0, 1);
        check("fe_no_hs", hs_cnt - hs0, 0);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        wait_cyc(10);
        check("fe_word", {16'h0, last_word}, 32'h6677);
        check("fe_total", fe_cnt - fe0, 1);

        // Frame error dropping a stored high byte
        snap();
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b0);
        RX = 1'b1;
        wait_cyc(20);
        send_byte(8'h21, 1'b1);
        send_byte(8'h65, 1'b1);
        wait_cyc(10);
        check("fe_drop_hs", hs_cnt - hs0, 1);
        check("fe_drop_word", {16'h0, last_word}, 32'h2165);

        // Break: long low gives exactly one FRAME_ERR
        snap();
        RX = 1'b0;
        wait_cyc(3000);
        RX = 1'b1;
        wait_cyc(300);
        check("break_fe", fe_cnt - fe0, 1);
        check("break_no_hs", hs_cnt - hs0, 0);

        // Reset after a high byte and mid-frame
        snap();
        send_byte(8'h9A, 1'b1);
        RX = 1'b0;
        wait_cyc(BIT_CYC * 4);
        RST_N = 1'b0;
        RX = 1'b1;
        wait_cyc(4);
        @(negedge CLK);
        check("mid_rst_valid", {31'h0, WORD_VALID}, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        wait_cyc(20);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_cyc(10);
        check("rst_hs", hs_cnt - hs0, 1);
        check("rst_word", {16'h0, last_word}, 32'h1122);
        check("rst_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

`ifdef UART_RX_PARITY_EN
        // Parity: bad parity drops the byte, then a good pair
        snap();
        bad_par = 1'b1;
        send_byte(8'h03, 1'b1);
        bad_par = 1'b0;
        wait_cyc(10);
        check("par_pulse", pe_cnt - pe0, 1);
        check("par_no_hs", hs_cnt - hs0, 0);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        wait_cyc(10);
        check("par_word", {16'h0, last_word}, 32'h0304);
        check("par_total", pe_cnt - pe0, 1);
`else
        check("par_tied", pe_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Serial receive front end for the COMET II board: samples the asynchronous UART line, deframes 8N1 bytes, and assembles pairs of bytes into 16-bit COMET II words for the program/data loader. It sits between the board RX pin and the memory loader. It replaces USB as the host-to-board path while USB stays disabled. The output is a single-entry valid/ready word port.

## Interface
- CLK_HZ, 16000000: core clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- CLK  in  1: 16 MHz board clock; all logic on rising edge.
- RST_N  in  1: synchronous, active-low reset.
- RX  in  1: asynchronous serial line, idle high.
- WORD_DATA  out  16: assembled word, first received byte in [15:8].
- WORD_VALID  out  1: WORD_DATA holds an unconsumed word.
- WORD_READY  in  1: consumer accepts the word when WORD_VALID && WORD_READY.
- FRAME_ERR  out  1: one-cycle pulse when a stop bit samples low.
- OVERRUN  out  1: one-cycle pulse when a completed word is dropped.
- PARITY_ERR  out  1: one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

## Operation
- RX passes through a 2-flop synchronizer with reset value 1. All decisions use the synchronized value.
- BIT_CYC = CLK_HZ/BAUD, integer-truncated (138 at defaults). HALF = BIT_CYC/2.
- Receive FSM:
  - IDLE: a synchronized 0 enters START with the counter cleared.
  - START: after HALF cycles, re-sample. On 1, the start is false: go to IDLE with no flags. On 0, enter DATA.
  - DATA: sample every BIT_CYC cycles, LSB first, 8 bits. Then go to PARITY if it is compiled in, else STOP.
  - PARITY: sample after BIT_CYC. Even parity over the data bits.
  - STOP: sample after BIT_CYC.
    - On 1, the byte is good: go to IDLE.
    - On 0, pulse FRAME_ERR, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronized RX is 1, then go to IDLE. A held-low break produces exactly one FRAME_ERR.
- Byte pairing:
  - A phase flag selects the high or low byte.
  - A good byte in the high phase is stored and toggles the phase.
  - A good byte in the low phase completes a word.
  - FRAME_ERR or PARITY_ERR discards the byte and forces the phase back to high, so a partial word is dropped.
- Word completion:
  - If the output slot is free, or is being handshaken in the same cycle, load WORD_DATA and set WORD_VALID.
  - Otherwise pulse OVERRUN, drop the new word, and keep the held word unchanged.
  - The phase returns to high in either case.
- WORD_VALID clears on handshake. WORD_DATA is stable while WORD_VALID=1.

## Timing
- Reset values:
  - Outputs: WORD_DATA=0, WORD_VALID=0, FRAME_ERR=0, OVERRUN=0, PARITY_ERR=0.
  - Internal: FSM=IDLE, phase=high, counter=0.
- Reset asserted mid-frame abandons the frame and any stored high byte. The next frame starts a fresh word.
- Bit sampling points are HALF + k*BIT_CYC cycles after the synchronized falling edge. The synchronizer adds 2 cycles.
- WORD_VALID rises 1 cycle after the stop-bit sample of the low byte. Error pulses occur 1 cycle after the offending sample.
- A handshake and a word completion in the same cycle load the new word with no OVERRUN. WORD_VALID stays high.
- A start edge accepted in the cycle right after a good STOP is legal. Back-to-back frames need no idle gap.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: frame is 8E1 with a PARITY state; a mismatch pulses PARITY_ERR and discards the byte.
  - Undefined: frame is 8N1, no PARITY state, and PARITY_ERR is driven constant 0.

## Structure
- Package uart_pkg holds:
  - The FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - A function computing BIT_CYC from CLK_HZ and BAUD.
  - The word width constant 16.
- Sub-module uart_rx_byte contains the synchronizer, divider and deframer. It outputs a byte-valid pulse plus error pulses.
- uart_rx_word wraps uart_rx_byte and adds byte pairing and the output slot.

## Test plan
- Send 0x12 then 0x34 at 115200, WORD_READY=1 -> WORD_VALID for 1 cycle with WORD_DATA=0x1234; no error pulses.
- Send 0xAB, 0xCD, 0xEF, 0x01 with WORD_READY=0 throughout -> word 0xABCD held; OVERRUN pulses once after 0x01; WORD_DATA stays 0xABCD.
- Apply a 3-cycle low glitch on RX -> START rejects it; no state change, no flags.
- Send 0x55 with the stop bit forced low, then 0x66 and 0x77 -> FRAME_ERR once; next word is 0x6677.
- Assert RST_N=0 after the high byte 0x9A, then send 0x11 and 0x22 -> WORD_DATA=0x1122.
- With UART_RX_PARITY_EN defined, send 0x03 with a wrong parity bit -> PARITY_ERR once, byte discarded; 0x03 with correct parity followed by 0x04 -> word 0x0304.
